// File: rtl/synth_mm_pkg.sv
// Shared types and address-map constants for the modulation-matrix writer.
package synth_mm_pkg;

   localparam logic [7:0] MM_MAT1_BASE   = 8'h00;
   localparam logic [7:0] MM_MAT2_BASE   = 8'h40;
   localparam logic [7:0] MM_OSCMOD_BASE = 8'h80;
   localparam logic [7:0] MM_OSCFB_BASE  = 8'h84;
   localparam logic [7:0] MM_MODIN_BASE  = 8'h88;
   localparam logic [7:0] MM_FBIN_BASE   = 8'h8C;
   localparam logic [7:0] MM_LAST        = 8'h8F;

   typedef enum logic [2:0] {
      MM_R_MAT1,
      MM_R_MAT2,
      MM_R_OSCMOD,
      MM_R_OSCFB,
      MM_R_MODIN,
      MM_R_FBIN,
      MM_R_NONE
   } mm_region_t;

   typedef enum logic [1:0] {
      MM_IDLE,
      MM_BATCH,
      MM_PENDING
   } mm_state_t;

endpackage

// File: rtl/mm_addr_decode.sv
// Combinational register-address decoder: byte address -> {region, row, osc}.
// Used by both the write path and the optional readback path.
module mm_addr_decode
   import synth_mm_pkg::*;
#(
   parameter int unsigned O_WIDTH = 2,
   parameter int unsigned R_WIDTH = 4
) (
   input  logic [7:0]         addr,
   output mm_region_t         region,
   output logic [R_WIDTH-1:0] row,
   output logic [O_WIDTH-1:0] osc
);

   assign row = addr[O_WIDTH +: R_WIDTH];
   assign osc = addr[O_WIDTH-1:0];

   // Matrix regions are 64-byte aligned; oscillator regions are 4-byte blocks up to MM_LAST.
   always_comb begin
      region = MM_R_NONE;
      if (addr[7:6] == MM_MAT1_BASE[7:6]) begin
         region = MM_R_MAT1;
      end else if (addr[7:6] == MM_MAT2_BASE[7:6]) begin
         region = MM_R_MAT2;
      end else if (addr >= MM_OSCMOD_BASE && addr <= MM_LAST) begin
         if (addr[3:2] == MM_OSCMOD_BASE[3:2])      region = MM_R_OSCMOD;
         else if (addr[3:2] == MM_OSCFB_BASE[3:2])  region = MM_R_OSCFB;
         else if (addr[3:2] == MM_MODIN_BASE[3:2])  region = MM_R_MODIN;
         else if (addr[3:2] == MM_FBIN_BASE[3:2])   region = MM_R_FBIN;
         else                                       region = MM_R_NONE;
      end
   end

endmodule

// File: rtl/mod_matrix_writer.sv
// Modulation-matrix coefficient writer: byte writes land in a shadow bank and
// are copied atomically to the live outputs on frame_sync.
// Optional readback port enabled by defining MOD_MATRIX_READBACK_EN.
module mod_matrix_writer
   import synth_mm_pkg::*;
#(
   parameter int unsigned V_OSC    = 4,
   parameter int unsigned O_WIDTH  = 2,
   parameter int unsigned MAT_ROWS = 16
) (
   input  logic                                  sCLK_XVXENVS,
   input  logic                                  reset,
   input  logic                                  wr_valid,
   output logic                                  wr_ready,
   input  logic [7:0]                            wr_addr,
   input  logic [7:0]                            wr_data,
   input  logic                                  batch_begin,
   input  logic                                  batch_end,
   input  logic                                  frame_sync,
   input  logic                                  err_clr,
   output logic [MAT_ROWS-1:0][V_OSC-1:0][7:0]   mat_buf1,
   output logic [MAT_ROWS-1:0][V_OSC-1:0][7:0]   mat_buf2,
   output logic [V_OSC-1:0][7:0]                 osc_mod,
   output logic [V_OSC-1:0][7:0]                 osc_feedb,
   output logic [V_OSC-1:0][7:0]                 osc_mod_in,
   output logic [V_OSC-1:0][7:0]                 osc_feedb_in,
   output logic                                  pending,
   output logic                                  commit_pulse,
   output logic                                  err_addr
`ifdef MOD_MATRIX_READBACK_EN
   ,
   input  logic                                  rd_valid,
   input  logic [7:0]                            rd_addr,
   output logic [7:0]                            rd_data,
   output logic                                  rd_data_valid
`endif
);

   localparam int unsigned R_WIDTH = $clog2(MAT_ROWS);

   mm_state_t state, state_nxt;

   mm_region_t         wr_region;
   logic [R_WIDTH-1:0] wr_row;
   logic [O_WIDTH-1:0] wr_osc;
   logic               wr_fire;
   logic               wr_mapped;
   logic               commit;

   logic [MAT_ROWS-1:0][V_OSC-1:0][7:0] mat1_sh, mat2_sh;
   logic [V_OSC-1:0][7:0]               mod_sh, fb_sh, modin_sh, fbin_sh;

   mm_addr_decode #(.O_WIDTH(O_WIDTH), .R_WIDTH(R_WIDTH)) u_wr_dec (
      .addr   (wr_addr),
      .region (wr_region),
      .row    (wr_row),
      .osc    (wr_osc)
   );

   assign wr_fire   = wr_valid && wr_ready;
   assign wr_mapped = (wr_region != MM_R_NONE);
   assign commit    = (state == MM_PENDING) && frame_sync;

   // Next-state decode; batch_begin takes priority over a same-cycle write in IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         MM_IDLE: begin
            if (batch_begin)                state_nxt = MM_BATCH;
            else if (wr_fire && wr_mapped)  state_nxt = MM_PENDING;
         end
         MM_BATCH: begin
            if (batch_end)                  state_nxt = MM_PENDING;
         end
         MM_PENDING: begin
            if (frame_sync)                 state_nxt = MM_IDLE;
         end
         default:                           state_nxt = MM_IDLE;
      endcase
   end

   // FSM state and its registered handshake/status outputs.
   always_ff @(posedge sCLK_XVXENVS or posedge reset) begin
      if (reset) begin
         state        <= MM_IDLE;
         wr_ready     <= 1'b0;
         pending      <= 1'b0;
         commit_pulse <= 1'b0;
      end else begin
         state        <= state_nxt;
         wr_ready     <= (state_nxt != MM_PENDING);
         pending      <= (state_nxt == MM_PENDING);
         commit_pulse <= commit;
      end
   end

   // Sticky unmapped-address flag; a new error in the clearing cycle wins.
   always_ff @(posedge sCLK_XVXENVS or posedge reset) begin
      if (reset)                        err_addr <= 1'b0;
      else if (wr_fire && !wr_mapped)   err_addr <= 1'b1;
      else if (err_clr)                 err_addr <= 1'b0;
   end

   // Shadow bank: accepted mapped writes stored verbatim.
   always_ff @(posedge sCLK_XVXENVS or posedge reset) begin
      if (reset) begin
         mat1_sh  <= '0;
         mat2_sh  <= '0;
         mod_sh   <= '0;
         fb_sh    <= '0;
         modin_sh <= '0;
         fbin_sh  <= '0;
      end else if (wr_fire) begin
         case (wr_region)
            MM_R_MAT1:   mat1_sh[wr_row][wr_osc] <= wr_data;
            MM_R_MAT2:   mat2_sh[wr_row][wr_osc] <= wr_data;
            MM_R_OSCMOD: mod_sh[wr_osc]          <= wr_data;
            MM_R_OSCFB:  fb_sh[wr_osc]           <= wr_data;
            MM_R_MODIN:  modin_sh[wr_osc]        <= wr_data;
            MM_R_FBIN:   fbin_sh[wr_osc]         <= wr_data;
            default:     ;
         endcase
      end
   end

   // Live bank: whole-set copy from shadow at the commit edge.
   always_ff @(posedge sCLK_XVXENVS or posedge reset) begin
      if (reset) begin
         mat_buf1     <= '0;
         mat_buf2     <= '0;
         osc_mod      <= '0;
         osc_feedb    <= '0;
         osc_mod_in   <= '0;
         osc_feedb_in <= '0;
      end else if (commit) begin
         mat_buf1     <= mat1_sh;
         mat_buf2     <= mat2_sh;
         osc_mod      <= mod_sh;
         osc_feedb    <= fb_sh;
         osc_mod_in   <= modin_sh;
         osc_feedb_in <= fbin_sh;
      end
   end

`ifdef MOD_MATRIX_READBACK_EN
   mm_region_t         rd_region, rd_region_q;
   logic [R_WIDTH-1:0] rd_row, rd_row_q;
   logic [O_WIDTH-1:0] rd_osc, rd_osc_q;
   logic               rd_valid_q;

   mm_addr_decode #(.O_WIDTH(O_WIDTH), .R_WIDTH(R_WIDTH)) u_rd_dec (
      .addr   (rd_addr),
      .region (rd_region),
      .row    (rd_row),
      .osc    (rd_osc)
   );

   // Two-stage read: register the decoded address, then register the shadow mux.
   always_ff @(posedge sCLK_XVXENVS or posedge reset) begin
      if (reset) begin
         rd_region_q   <= MM_R_NONE;
         rd_row_q      <= '0;
         rd_osc_q      <= '0;
         rd_valid_q    <= 1'b0;
         rd_data       <= '0;
         rd_data_valid <= 1'b0;
      end else begin
         rd_region_q   <= rd_region;
         rd_row_q      <= rd_row;
         rd_osc_q      <= rd_osc;
         rd_valid_q    <= rd_valid;
         rd_data_valid <= rd_valid_q;
         case (rd_region_q)
            MM_R_MAT1:   rd_data <= mat1_sh[rd_row_q][rd_osc_q];
            MM_R_MAT2:   rd_data <= mat2_sh[rd_row_q][rd_osc_q];
            MM_R_OSCMOD: rd_data <= mod_sh[rd_osc_q];
            MM_R_OSCFB:  rd_data <= fb_sh[rd_osc_q];
            MM_R_MODIN:  rd_data <= modin_sh[rd_osc_q];
            MM_R_FBIN:   rd_data <= fbin_sh[rd_osc_q];
            default:     rd_data <= '0;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_mod_matrix_writer.sv
// Directed bench for mod_matrix_writer with a commit scoreboard.
// Readback checks are compiled when MOD_MATRIX_READBACK_EN is defined.
module tb_mod_matrix_writer;

   typedef struct packed {
      logic [15:0][3:0][7:0] b1;
      logic [15:0][3:0][7:0] b2;
      logic [3:0][7:0]       om;
      logic [3:0][7:0]       ofb;
      logic [3:0][7:0]       omi;
      logic [3:0][7:0]       ofbi;
   } snap_t;

   logic clk = 1'b0;
   logic reset;
   logic wr_valid, wr_ready;
   logic [7:0] wr_addr, wr_data;
   logic batch_begin, batch_end, frame_sync, err_clr;
   logic [15:0][3:0][7:0] mat_buf1, mat_buf2;
   logic [3:0][7:0] osc_mod, osc_feedb, osc_mod_in, osc_feedb_in;
   logic pending, commit_pulse, err_addr;
`ifdef MOD_MATRIX_READBACK_EN
   logic rd_valid;
   logic [7:0] rd_addr, rd_data;
   logic rd_data_valid;
`endif

   int checks = 0;
   int errors = 0;

   snap_t sh_m;      // model of the shadow bank
   snap_t live_m;    // model of the live outputs
   snap_t sb [$];    // expected live sets, one per expected commit
   snap_t popped;

   always #5 clk = ~clk;

   mod_matrix_writer #(.V_OSC(4), .O_WIDTH(2), .MAT_ROWS(16)) dut (
      .sCLK_XVXENVS (clk),
      .reset        (reset),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .batch_begin  (batch_begin),
      .batch_end    (batch_end),
      .frame_sync   (frame_sync),
      .err_clr      (err_clr),
      .mat_buf1     (mat_buf1),
      .mat_buf2     (mat_buf2),
      .osc_mod      (osc_mod),
      .osc_feedb    (osc_feedb),
      .osc_mod_in   (osc_mod_in),
      .osc_feedb_in (osc_feedb_in),
      .pending      (pending),
      .commit_pulse (commit_pulse),
      .err_addr     (err_addr)
`ifdef MOD_MATRIX_READBACK_EN
      ,
      .rd_valid      (rd_valid),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .rd_data_valid (rd_data_valid)
`endif
   );

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_live(input string tag);
      chk({tag, ".mat_buf1"},     mat_buf1,     live_m.b1);
      chk({tag, ".mat_buf2"},     mat_buf2,     live_m.b2);
      chk({tag, ".osc_mod"},      osc_mod,      live_m.om);
      chk({tag, ".osc_feedb"},    osc_feedb,    live_m.ofb);
      chk({tag, ".osc_mod_in"},   osc_mod_in,   live_m.omi);
      chk({tag, ".osc_feedb_in"}, osc_feedb_in, live_m.ofbi);
   endtask

   // Independent address-map model of the shadow bank.
   task automatic model_wr(input logic [7:0] a, input logic [7:0] d);
      if (a < 8'h40)       sh_m.b1[a[5:2]][a[1:0]] = d;
      else if (a < 8'h80)  sh_m.b2[a[5:2]][a[1:0]] = d;
      else if (a < 8'h84)  sh_m.om[a[1:0]]   = d;
      else if (a < 8'h88)  sh_m.ofb[a[1:0]]  = d;
      else if (a < 8'h8C)  sh_m.omi[a[1:0]]  = d;
      else if (a < 8'h90)  sh_m.ofbi[a[1:0]] = d;
   endtask

   // One write with a bounded wait for wr_ready.
   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      int unsigned n;
      n = 0;
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      while (wr_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk("wr_ready_wait", wr_ready, 1'b1);
      if (wr_ready === 1'b1) begin
         tick();
         model_wr(a, d);
      end
      wr_valid = 1'b0;
   endtask

   // One-cycle frame strobe; when a commit is expected, the shadow model becomes the live model.
   task automatic frame(input bit expect_commit);
      frame_sync = 1'b1;
      if (expect_commit) begin
         sb.push_back(sh_m);
         live_m = sh_m;
      end
      tick();
      frame_sync = 1'b0;
   endtask

   // Scoreboard: every commit_pulse must match a queued expected live set.
   always @(negedge clk) begin
      if (commit_pulse === 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_commit", 1'b1, 1'b0);
         end else begin
            popped = sb.pop_front();
            chk("sb.mat_buf1",     mat_buf1,     popped.b1);
            chk("sb.mat_buf2",     mat_buf2,     popped.b2);
            chk("sb.osc_mod",      osc_mod,      popped.om);
            chk("sb.osc_feedb",    osc_feedb,    popped.ofb);
            chk("sb.osc_mod_in",   osc_mod_in,   popped.omi);
            chk("sb.osc_feedb_in", osc_feedb_in, popped.ofbi);
         end
      end
   end

   initial begin
      sh_m   = '0;
      live_m = '0;
      reset = 1'b1;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      batch_begin = 1'b0; batch_end = 1'b0; frame_sync = 1'b0; err_clr = 1'b0;
`ifdef MOD_MATRIX_READBACK_EN
      rd_valid = 1'b0; rd_addr = '0;
`endif

      // Reset
      tick(); tick();
      chk("rst.wr_ready_in_reset", wr_ready, 1'b0);
      reset = 1'b0;
      tick();
      chk("rst.wr_ready", wr_ready, 1'b1);
      chk("rst.pending", pending, 1'b0);
      chk("rst.commit_pulse", commit_pulse, 1'b0);
      chk("rst.err_addr", err_addr, 1'b0);
      chk_live("rst");

      // Single write, commit on frame
      wr(8'h05, 8'h7F);
      chk("single.pending", pending, 1'b1);
      chk("single.wr_ready", wr_ready, 1'b0);
      chk_live("single.pre");
      frame(1'b1);
      chk_live("single.post");
      chk("single.commit_pulse", commit_pulse, 1'b1);
      chk("single.mb1_11", mat_buf1[1][1], 8'h7F);
      chk("single.wr_ready_post", wr_ready, 1'b1);
      tick();
      chk("single.commit_pulse_off", commit_pulse, 1'b0);

      // Batch with a mid-batch frame strobe
      batch_begin = 1'b1;
      wr(8'h40, 8'hFD);
      batch_begin = 1'b0;
      frame(1'b0);
      chk_live("batch.mid1");
      chk("batch.pending_mid", pending, 1'b0);
      wr(8'h83, 8'h40);
      frame(1'b0);
      chk_live("batch.mid2");
      chk("batch.commit_mid", commit_pulse, 1'b0);
      batch_end = 1'b1;
      tick();
      batch_end = 1'b0;
      chk("batch.pending", pending, 1'b1);
      chk_live("batch.pre");
      frame(1'b1);
      chk_live("batch.post");
      chk("batch.mb2_00", mat_buf2[0][0], 8'hFD);
      chk("batch.om_3", osc_mod[3], 8'h40);
      tick();

      // Unmapped write
      wr(8'hA0, 8'h55);
      chk("bad.err_addr", err_addr, 1'b1);
      chk("bad.pending", pending, 1'b0);
      chk("bad.wr_ready", wr_ready, 1'b1);
      chk_live("bad");
      err_clr = 1'b1;
      wr(8'hA1, 8'h66);
      err_clr = 1'b0;
      chk("bad.set_wins", err_addr, 1'b1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("bad.cleared", err_addr, 1'b0);

      // Write held through PENDING
      wr(8'h10, 8'h22);
      wr_valid = 1'b1; wr_addr = 8'h8C; wr_data = 8'h0C;
      tick(); tick(); tick();
      chk("hold.wr_ready", wr_ready, 1'b0);
      chk("hold.pending", pending, 1'b1);
      frame(1'b1);
      chk("hold.wr_ready_after", wr_ready, 1'b1);
      chk_live("hold.commit1");
      tick();
      model_wr(8'h8C, 8'h0C);
      wr_valid = 1'b0;
      chk("hold.accepted_pending", pending, 1'b1);
      chk_live("hold.pre2");
      frame(1'b1);
      chk("hold.ofbi_0", osc_feedb_in[0], 8'h0C);
      chk_live("hold.post2");
      tick();

      // Reset in the middle of a batch
      batch_begin = 1'b1;
      tick();
      batch_begin = 1'b0;
      wr(8'h00, 8'h01);
      wr(8'h44, 8'h02);
      wr(8'h81, 8'h03);
      reset = 1'b1;
      sh_m   = '0;
      live_m = '0;
      tick();
      reset = 1'b0;
      tick();
      chk_live("rstmid");
      chk("rstmid.pending", pending, 1'b0);
      chk("rstmid.wr_ready", wr_ready, 1'b1);
      frame(1'b0);
      chk("rstmid.no_commit", commit_pulse, 1'b0);
      chk("rstmid.pending2", pending, 1'b0);
      wr(8'h01, 8'h11);
      frame(1'b1);
      chk_live("rstmid.shadow_cleared");
      tick();

`ifdef MOD_MATRIX_READBACK_EN
      // Readback of shadow before commit
      wr(8'h7F, 8'hFF);
      rd_valid = 1'b1; rd_addr = 8'h7F;
      tick();
      rd_valid = 1'b0;
      chk("rd.valid_lat1", rd_data_valid, 1'b0);
      tick();
      chk("rd.data", rd_data, 8'hFF);
      chk("rd.valid", rd_data_valid, 1'b1);
      chk("rd.live_still_0", mat_buf2[15][3], 8'h00);
      rd_valid = 1'b1; rd_addr = 8'hA0;
      tick();
      rd_valid = 1'b0;
      tick();
      chk("rd.unmapped", rd_data, 8'h00);
      chk("rd.valid2", rd_data_valid, 1'b1);
      frame(1'b1);
      chk_live("rd.commit");
      tick();
`endif

      tick(); tick();
      chk("sb.drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
